// File: rtl/cordic_pkg.sv
// Shared types and elaboration-time constants for the iterative CORDIC engine.
// Optional gain compensation is enabled by defining CORDIC_GAIN_COMP_EN.
package cordic_pkg;

  typedef enum logic [2:0] {
    st_idle,
    st_load,
    st_iter,
    st_scale,
    st_done
  } state_t;

  localparam logic mode_vec = 1'b0;
  localparam logic mode_rot = 1'b1;

  localparam real pi    = 3.14159265358979323846;
  localparam real inv_k = 0.60725293500888125617;

  // Whole-degree constant expressed with afrac fractional bits.
  function automatic longint deg_q(input int deg, input int afrac);
    return longint'(deg) <<< afrac;
  endfunction

  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    for (int k = 0; k < e; k++) r = r * 2.0;
    return r;
  endfunction

  // atan(2^-i) in degrees, afrac fractional bits, rounded to nearest.
  // Series is exact enough for i>=1 (t<=0.5); i=0 is pi/4 directly.
  function automatic longint atan_q(input int i, input int afrac);
    real t, t2, term, sum;
    t = 1.0 / pow2(i);
    if (i == 0) begin
      sum = pi / 4.0;
    end else begin
      sum  = 0.0;
      term = t;
      t2   = t * t;
      for (int k = 0; k < 40; k++) begin
        if ((k % 2) == 0) sum = sum + term / real'(2 * k + 1);
        else              sum = sum - term / real'(2 * k + 1);
        term = term * t2;
      end
    end
    return longint'(sum * 180.0 / pi * pow2(afrac));
  endfunction

  // 1/K with the given number of fractional bits, rounded to nearest.
  function automatic longint inv_k_q(input int bits);
    return longint'(inv_k * pow2(bits));
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table: data = atan(2^-addr) in degrees, AFRAC fractional bits.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int AW    = 32,
  parameter int AFRAC = 23,
  parameter int NITER = 24
)(
  input  logic [((NITER > 1) ? $clog2(NITER) : 1)-1:0] addr,
  output logic [AW-1:0]                                data
);

  localparam int AB = (NITER > 1) ? $clog2(NITER) : 1;

  logic [AW-1:0] rom [2**AB];

  for (genvar gi = 0; gi < 2**AB; gi++) begin : g_rom
    if (gi < NITER) begin : g_ent
      localparam longint ent = atan_q(gi, AFRAC);
      assign rom[gi] = AW'(ent);
    end else begin : g_pad
      assign rom[gi] = '0;
    end
  end

  assign data = rom[addr];

endmodule

// File: rtl/cordic_engine.sv
// Iterative four-quadrant CORDIC, vectoring or rotation, one micro-rotation per enabled clock.
// Define CORDIC_GAIN_COMP_EN to add a SCALE cycle that removes the CORDIC gain K.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int DW    = 32,
  parameter int FRAC  = 16,
  parameter int AW    = 32,
  parameter int AFRAC = 23,
  parameter int NITER = 24,
  parameter int GUARD = 2
)(
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          start,
  input  logic          mode,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] y_in,
  input  logic [AW-1:0] z_in,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] x_out,
  output logic [DW-1:0] y_out,
  output logic [AW-1:0] z_out
);

  localparam int IW = DW + GUARD;
  localparam int ZW = AW + 1;
  localparam int CW = (NITER > 1) ? $clog2(NITER) : 1;
  localparam logic signed [ZW-1:0] deg90     = ZW'(deg_q(90, AFRAC));
  localparam logic        [CW-1:0] last_iter = CW'(NITER - 1);

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic                 mode_reg, mode_next;
  logic signed [IW-1:0] x_reg, x_next, y_reg, y_next;
  logic signed [ZW-1:0] z_reg, z_next;
  logic [DW-1:0]        x_out_reg, x_out_next, y_out_reg, y_out_next;
  logic [AW-1:0]        z_out_reg, z_out_next;
  logic                 busy_reg, busy_next, done_reg, done_next;

  logic [AW-1:0]        atan_val;
  logic signed [ZW-1:0] atan_z;
  logic signed [IW-1:0] x_sh, y_sh, x_iter, y_iter, x_pre, y_pre;
  logic signed [ZW-1:0] z_iter, z_pre;
  logic                 d_pos;

  function automatic logic [DW-1:0] sat_xy(input logic signed [IW-1:0] v);
    if (&v[IW-1:DW-1] || ~|v[IW-1:DW-1]) return v[DW-1:0];
    return v[IW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction

  function automatic logic [AW-1:0] sat_z(input logic signed [ZW-1:0] v);
    if (&v[ZW-1:AW-1] || ~|v[ZW-1:AW-1]) return v[AW-1:0];
    return v[ZW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
  endfunction

  cordic_atan_rom #(
    .AW    (AW),
    .AFRAC (AFRAC),
    .NITER (NITER)
  ) u_atan_rom (
    .addr (cnt_reg),
    .data (atan_val)
  );

  assign atan_z = signed'({1'b0, atan_val});
  assign x_sh   = x_reg >>> cnt_reg;
  assign y_sh   = y_reg >>> cnt_reg;

  // An exactly-zero y in vectoring mode steers by z instead, so a zero vector
  // walks z back towards 0 rather than accumulating the whole atan table.
  always_comb begin
    d_pos = 1'b0;
    if (mode_reg == mode_rot) d_pos = ~z_reg[ZW-1];
    else                      d_pos = y_reg[IW-1] | ((y_reg == '0) & ~z_reg[ZW-1]);
  end

  assign x_iter = d_pos ? (x_reg - y_sh) : (x_reg + y_sh);
  assign y_iter = d_pos ? (y_reg + x_sh) : (y_reg - x_sh);
  assign z_iter = d_pos ? (z_reg - atan_z) : (z_reg + atan_z);

  // Exact +/-90 degree pre-rotation bringing the operand into the convergence range.
  always_comb begin
    x_pre = x_reg;
    y_pre = y_reg;
    z_pre = z_reg;
    if (mode_reg == mode_vec) begin
      z_pre = '0;
      if (x_reg[IW-1]) begin
        if (y_reg[IW-1]) begin
          x_pre = -y_reg;
          y_pre = x_reg;
          z_pre = -deg90;
        end else begin
          x_pre = y_reg;
          y_pre = -x_reg;
          z_pre = deg90;
        end
      end
    end else if (z_reg > deg90) begin
      x_pre = -y_reg;
      y_pre = x_reg;
      z_pre = z_reg - deg90;
    end else if (z_reg < -deg90) begin
      x_pre = y_reg;
      y_pre = -x_reg;
      z_pre = z_reg + deg90;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int KB = FRAC + 2;
  localparam logic signed [KB:0]    invk = (KB+1)'(inv_k_q(KB));
  localparam logic signed [IW+KB:0] rnd  = (IW+KB+1)'(1) << (KB - 1);

  logic signed [IW+KB:0] x_prod, y_prod;
  logic signed [IW-1:0]  x_scl, y_scl;

  assign x_prod = x_reg * invk + rnd;
  assign y_prod = y_reg * invk + rnd;
  assign x_scl  = x_prod[IW+KB-1:KB];
  assign y_scl  = y_prod[IW+KB-1:KB];
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    z_next     = z_reg;
    x_out_next = x_out_reg;
    y_out_next = y_out_reg;
    z_out_next = z_out_reg;
    case (state_reg)
      st_idle: begin
        if (start) begin
          state_next = st_load;
          mode_next  = mode;
          x_next     = IW'(signed'(x_in));
          y_next     = IW'(signed'(y_in));
          z_next     = ZW'(signed'(z_in));
        end
      end
      st_load: begin
        if (enable) begin
          state_next = st_iter;
          cnt_next   = '0;
          x_next     = x_pre;
          y_next     = y_pre;
          z_next     = z_pre;
        end
      end
      st_iter: begin
        if (enable) begin
          x_next   = x_iter;
          y_next   = y_iter;
          z_next   = z_iter;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == last_iter) begin
            cnt_next = '0;
`ifdef CORDIC_GAIN_COMP_EN
            state_next = st_scale;
`else
            state_next = st_done;
            x_out_next = sat_xy(x_iter);
            y_out_next = sat_xy(y_iter);
            z_out_next = sat_z(z_iter);
`endif
          end
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      st_scale: begin
        if (enable) begin
          state_next = st_done;
          x_out_next = sat_xy(x_scl);
          y_out_next = sat_xy(y_scl);
          z_out_next = sat_z(z_reg);
        end
      end
`endif
      st_done: begin
        if (enable) state_next = st_idle;
      end
      default: state_next = st_idle;
    endcase
    busy_next = (state_next == st_load) || (state_next == st_iter) || (state_next == st_scale);
    done_next = (state_next == st_done);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= st_idle;
      cnt_reg   <= '0;
      mode_reg  <= mode_vec;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      x_out_reg <= '0;
      y_out_reg <= '0;
      z_out_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      z_reg     <= z_next;
      x_out_reg <= x_out_next;
      y_out_reg <= y_out_next;
      z_out_reg <= z_out_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign x_out = x_out_reg;
  assign y_out = y_out_reg;
  assign z_out = z_out_reg;

endmodule
